// File: rtl/outport_alloc_if.sv
// Output-port allocator bus: head requests and flit status from the input buffers,
// lock/crossbar/dequeue/credit status back to them.
interface outport_alloc_if #(
   parameter int PORT_N = 5,
   parameter int CW     = 3
);
   localparam int SW = $clog2(PORT_N);

   logic [PORT_N-1:0] u_req;
   logic [PORT_N-1:0] m_req;
   logic [PORT_N-1:0] multab_ct;
   logic [PORT_N-1:0] flit_vld;
   logic [PORT_N-1:0] flit_tail;
   logic              credit_in;

   // Handshake: flit_vld[i] is the valid of input i and is never gated by this block;
   // a flit moves in exactly the cycle xfer[i] is high, which only happens for the lock
   // owner while credit_cnt != 0. xfer is the ready/dequeue strobe, out_vld its copy.
   logic [PORT_N-1:0] grt;
   logic [SW-1:0]     sel;
   logic              busy;
   logic [PORT_N-1:0] xfer;
   logic              out_vld;
   logic [CW-1:0]     credit_cnt;
   logic              credit_err;

   modport master (
      output u_req, m_req, multab_ct, flit_vld, flit_tail, credit_in,
      input  grt, sel, busy, xfer, out_vld, credit_cnt, credit_err
   );

   modport slave (
      input  u_req, m_req, multab_ct, flit_vld, flit_tail, credit_in,
      output grt, sel, busy, xfer, out_vld, credit_cnt, credit_err
   );
endinterface

// File: rtl/outport_alloc.sv
// Wormhole allocator for one router output: multicast-first rotating arbitration,
// lock until tail, credit-gated flit transfer.
module outport_alloc #(
   parameter int PORT_N     = 5,
   parameter int CREDIT_MAX = 4,
   parameter int CW         = 3
) (
   input  logic             clk,
   input  logic             rst_,
   outport_alloc_if.slave   bus,
   output logic             dbg_state
);
   localparam int SW = $clog2(PORT_N);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

   state_e            state_q, state_d;
   logic [PORT_N-1:0] grt_q, grt_d;
   logic [SW-1:0]     sel_q, sel_d;
   logic              busy_q, busy_d;
   logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]     credit_cnt_q, credit_cnt_d;
   logic              credit_err_q, credit_err_d;

   logic [PORT_N-1:0] cand;
   logic              win_vld;
   logic [SW-1:0]     win_id;
   logic              out_vld;
   int                idx;

   // A pending multicast hides unicast even when all multicast heads are masked.
   always_comb begin
      cand    = (|bus.m_req) ? (bus.m_req & ~bus.multab_ct) : bus.u_req;
      win_vld = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int k = 1; k <= PORT_N; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= PORT_N) idx = idx - PORT_N;
         if (!win_vld && cand[idx]) begin
            win_vld = 1'b1;
            win_id  = SW'(idx);
         end
      end
   end

   always_comb begin
      out_vld = (state_q == LOCKED) && bus.flit_vld[sel_q] && (credit_cnt_q != '0);
   end

   always_comb begin
      state_d  = state_q;
      grt_d    = grt_q;
      sel_d    = sel_q;
      busy_d   = busy_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d  = LOCKED;
               grt_d    = PORT_N'(1) << win_id;
               sel_d    = win_id;
               busy_d   = 1'b1;
               rr_ptr_d = win_id;
            end
         end
         LOCKED: begin
            if (out_vld && bus.flit_tail[sel_q]) begin
               state_d = IDLE;
               grt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Send and return in the same cycle cancel; a return with no room is an overflow.
   always_comb begin
      credit_cnt_d = credit_cnt_q;
      credit_err_d = credit_err_q;
      if (out_vld && !bus.credit_in) begin
         credit_cnt_d = credit_cnt_q - CW'(1);
      end else if (!out_vld && bus.credit_in) begin
         if (credit_cnt_q == CW'(CREDIT_MAX)) credit_err_d = 1'b1;
         else                                 credit_cnt_d = credit_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= IDLE;
         grt_q        <= '0;
         sel_q        <= '0;
         busy_q       <= 1'b0;
         rr_ptr_q     <= SW'(PORT_N - 1);
         credit_cnt_q <= CW'(CREDIT_MAX);
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grt_q        <= grt_d;
         sel_q        <= sel_d;
         busy_q       <= busy_d;
         rr_ptr_q     <= rr_ptr_d;
         credit_cnt_q <= credit_cnt_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign bus.grt        = grt_q;
   assign bus.sel        = sel_q;
   assign bus.busy       = busy_q;
   assign bus.out_vld    = out_vld;
   assign bus.xfer       = out_vld ? (PORT_N'(1) << sel_q) : '0;
   assign bus.credit_cnt = credit_cnt_q;
   assign bus.credit_err = credit_err_q;
   assign dbg_state      = state_q;
endmodule

// File: tb/tb_outport_alloc.sv
// Bench for outport_alloc: directed scenarios, a per-cycle reference model of the
// allocation rules, and literal checks on grant order, credit stalls and reset.
module tb_outport_alloc;
   localparam int N  = 5;
   localparam int CM = 4;

   logic clk  = 1'b0;
   logic rst_ = 1'b0;
   logic dbg_state;

   outport_alloc_if #(.PORT_N(N), .CW(3)) ifc ();

   outport_alloc #(.PORT_N(N), .CREDIT_MAX(CM), .CW(3)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .bus       (ifc.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_owner = -1;
   int m_sel   = 0;
   int m_rr    = N - 1;
   int m_cred  = CM;
   int m_err   = 0;

   function automatic int pick(input logic [N-1:0] cand, input int rr);
      int best = -1;
      int bd   = N + 1;
      for (int i = 0; i < N; i++) begin
         int d = (i - rr - 1 + 2 * N) % N;
         if (cand[i] && d < bd) begin
            bd   = d;
            best = i;
         end
      end
      return best;
   endfunction

   function automatic int model_out_vld();
      if (m_owner < 0) return 0;
      return (ifc.flit_vld[m_owner] && m_cred > 0) ? 1 : 0;
   endfunction

   always @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         m_owner = -1; m_sel = 0; m_rr = N - 1; m_cred = CM; m_err = 0;
      end else begin
         int ov;
         int nxt_owner;
         ov = model_out_vld();
         nxt_owner = m_owner;
         if (ifc.credit_in && !ov && m_cred == CM) m_err = 1;
         else m_cred = m_cred - ov + int'(ifc.credit_in);
         if (m_owner < 0) begin
            logic [N-1:0] c;
            int w;
            c = (ifc.m_req != 0) ? (ifc.m_req & ~ifc.multab_ct) : ifc.u_req;
            w = pick(c, m_rr);
            if (w >= 0) begin
               nxt_owner = w; m_sel = w; m_rr = w;
            end
         end else if (ov && ifc.flit_tail[m_owner]) begin
            nxt_owner = -1;
         end
         m_owner = nxt_owner;
      end
   end

   // ---------------- per-cycle compare + observation log ----------------
   logic [2:0] exp_q[$];
   logic [2:0] dut_grants[$];
   int         grant_cyc[$];
   int         xfer_cnt = 0;
   int         cyc      = 0;
   logic [N-1:0] prev_grt = '0;

   always @(negedge clk) begin
      int ov;
      #4;
      cyc++;
      ov = model_out_vld();
      chk("grt",        int'(ifc.grt),        (m_owner >= 0) ? (1 << m_owner) : 0);
      chk("sel",        int'(ifc.sel),        m_sel);
      chk("busy",       int'(ifc.busy),       (m_owner >= 0) ? 1 : 0);
      chk("out_vld",    int'(ifc.out_vld),    ov);
      chk("xfer",       int'(ifc.xfer),       ov ? (1 << m_owner) : 0);
      chk("credit_cnt", int'(ifc.credit_cnt), m_cred);
      chk("credit_err", int'(ifc.credit_err), m_err);
      if (prev_grt == '0 && ifc.grt != '0) begin
         dut_grants.push_back(ifc.sel);
         grant_cyc.push_back(cyc);
      end
      if (ifc.xfer != '0) xfer_cnt++;
      prev_grt = ifc.grt;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic peek();
      #4;
   endtask

   task automatic set_in(input logic [N-1:0] u, input logic [N-1:0] m, input logic [N-1:0] mc,
                         input logic [N-1:0] v, input logic [N-1:0] t, input logic ci);
      ifc.u_req = u; ifc.m_req = m; ifc.multab_ct = mc;
      ifc.flit_vld = v; ifc.flit_tail = t; ifc.credit_in = ci;
   endtask

   task automatic clear_in();
      set_in('0, '0, '0, '0, '0, 1'b0);
   endtask

   initial begin
      clear_in();
      // Reset with random inputs
      for (int i = 0; i < 5; i++) begin
         tick();
         set_in(N'($urandom_range(0, 31)), N'($urandom_range(0, 31)), N'($urandom_range(0, 31)),
                N'($urandom_range(0, 31)), N'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         peek();
         chk("rst_busy", int'(ifc.busy), 0);
         chk("rst_xfer", int'(ifc.xfer), 0);
         chk("rst_credit", int'(ifc.credit_cnt), 4);
      end
      tick(); rst_ = 1'b1; set_in(5'b11111, '0, '0, '0, '0, 1'b0);
      tick(); set_in('0, '0, '0, 5'b11111, 5'b11111, 1'b1); peek();
      chk("first_grant_p0", int'(ifc.grt), 5'b00001);

      // Rotation: 2-flit packets on ports 1 and 2
      tick(); clear_in();
      dut_grants.delete(); grant_cyc.delete(); xfer_cnt = 0;
      for (int p = 0; p < 4; p++) begin
         set_in(5'b00110, '0, '0, 5'b00110, '0, 1'b0);        tick();
         set_in(5'b00110, '0, '0, 5'b00110, '0, 1'b1);        tick();
         set_in(5'b00110, '0, '0, 5'b00110, 5'b00110, 1'b1);  tick();
      end
      clear_in(); tick(); peek();
      exp_q = '{3'd1, 3'd2, 3'd1, 3'd2};
      chk("rot_grant_count", dut_grants.size(), 4);
      for (int i = 0; i < 4 && i < dut_grants.size(); i++)
         chk("rot_grant_order", int'(dut_grants[i]), int'(exp_q[i]));
      for (int i = 1; i < grant_cyc.size(); i++)
         chk("rot_grant_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
      chk("rot_xfer_total", xfer_cnt, 8);

      // Multicast priority over unicast
      tick(); set_in(5'b00001, 5'b01000, '0, '0, '0, 1'b0);
      tick(); set_in('0, '0, '0, 5'b01000, 5'b01000, 1'b1); peek();
      chk("mc_grant", int'(ifc.grt), 5'b01000);
      tick(); clear_in();
      tick(); set_in(5'b00001, 5'b01000, 5'b01000, '0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); peek();
         chk("mc_masked_no_grant", int'(ifc.grt), 0);
      end
      tick(); set_in(5'b00001, '0, '0, '0, '0, 1'b0);
      tick(); set_in('0, '0, '0, 5'b00001, 5'b00001, 1'b1); peek();
      chk("uc_after_mc_drop", int'(ifc.grt), 5'b00001);

      // Credit stall on a 6-flit packet from port 2
      tick(); set_in(5'b00100, '0, '0, '0, '0, 1'b0);
      tick(); xfer_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         set_in('0, '0, '0, 5'b00100, '0, 1'b0); tick();
      end
      for (int i = 0; i < 2; i++) begin
         peek();
         chk("stall_credit0", int'(ifc.credit_cnt), 0);
         chk("stall_out_vld", int'(ifc.out_vld), 0);
         chk("stall_xfer", int'(ifc.xfer), 0);
         tick();
      end
      set_in('0, '0, '0, 5'b00100, '0, 1'b1); tick();
      set_in('0, '0, '0, 5'b00100, '0, 1'b0); peek();
      chk("stall_one_xfer", int'(ifc.xfer), 5'b00100);
      tick(); peek();
      chk("stall_again_xfer", int'(ifc.xfer), 0);
      chk("stall_again_credit", int'(ifc.credit_cnt), 0);
      tick(); set_in('0, '0, '0, 5'b00100, '0, 1'b1);
      tick(); set_in('0, '0, '0, 5'b00100, 5'b00100, 1'b1); peek();
      chk("stall_tail_send", int'(ifc.out_vld), 1);
      tick(); clear_in(); peek();
      chk("send_plus_credit", int'(ifc.credit_cnt), 1);
      chk("stall_released", int'(ifc.busy), 0);
      chk("stall_xfer_total", xfer_cnt, 6);
      for (int i = 0; i < 3; i++) begin
         tick(); set_in('0, '0, '0, '0, '0, 1'b1);
      end
      tick(); clear_in();

      // Single-flit packet on port 4, then wrap to port 0
      tick(); set_in(5'b10001, '0, '0, '0, '0, 1'b0);
      tick(); set_in(5'b10001, '0, '0, 5'b10000, 5'b10000, 1'b1); peek();
      chk("wrap_grant_p4", int'(ifc.grt), 5'b10000);
      tick(); set_in(5'b10001, '0, '0, '0, '0, 1'b0); peek();
      chk("wrap_p4_released", int'(ifc.busy), 0);
      tick(); set_in('0, '0, '0, 5'b00001, 5'b00001, 1'b1); peek();
      chk("wrap_grant_p0", int'(ifc.grt), 5'b00001);
      tick(); clear_in();

      // Mid-packet asynchronous reset, then credit overflow
      tick(); set_in(5'b00010, '0, '0, '0, '0, 1'b0);
      tick(); set_in('0, '0, '0, 5'b00010, '0, 1'b1);
      tick(); set_in('0, '0, '0, 5'b00010, '0, 1'b1);
      #2 rst_ = 1'b0;
      #1;
      chk("async_rst_busy", int'(ifc.busy), 0);
      chk("async_rst_grt", int'(ifc.grt), 0);
      chk("async_rst_out_vld", int'(ifc.out_vld), 0);
      chk("async_rst_xfer", int'(ifc.xfer), 0);
      tick(); rst_ = 1'b1; set_in('0, '0, '0, '0, '0, 1'b1);
      tick(); clear_in(); peek();
      chk("overflow_err", int'(ifc.credit_err), 1);
      chk("overflow_sat", int'(ifc.credit_cnt), 4);
      tick(); tick(); peek();
      chk("overflow_sticky", int'(ifc.credit_err), 1);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
